// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM states and FIFO entry layout for the PS/2 decoder
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] DROP_PAUSE = 8'hE1;
  localparam logic [7:0] DROP_BAT   = 8'hAA;
  localparam logic [7:0] DROP_ACK   = 8'hFA;
  localparam logic [7:0] DROP_RSND  = 8'hFE;
  localparam logic [7:0] DROP_ECHO  = 8'hEE;
  localparam logic [7:0] DROP_ERR0  = 8'h00;
  localparam logic [7:0] DROP_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } fifo_entry_t;

  // Keyboard housekeeping bytes that never belong to a key sequence.
  function automatic logic is_dropped(input logic [7:0] b);
    return (b == DROP_PAUSE) || (b == DROP_BAT) || (b == DROP_ACK) ||
           (b == DROP_RSND) || (b == DROP_ECHO) || (b == DROP_ERR0) ||
           (b == DROP_ERR1);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// rtl/ps2_scan2ascii.sv - combinational Set-2 scan code to ASCII lookup
module ps2_scan2ascii (
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic       letter;

  always_comb begin
    lower  = 8'h00;
    letter = 1'b0;
    case (code)
      8'h1C: begin lower = "a"; letter = 1'b1; end
      8'h32: begin lower = "b"; letter = 1'b1; end
      8'h21: begin lower = "c"; letter = 1'b1; end
      8'h23: begin lower = "d"; letter = 1'b1; end
      8'h24: begin lower = "e"; letter = 1'b1; end
      8'h2B: begin lower = "f"; letter = 1'b1; end
      8'h34: begin lower = "g"; letter = 1'b1; end
      8'h33: begin lower = "h"; letter = 1'b1; end
      8'h43: begin lower = "i"; letter = 1'b1; end
      8'h3B: begin lower = "j"; letter = 1'b1; end
      8'h42: begin lower = "k"; letter = 1'b1; end
      8'h4B: begin lower = "l"; letter = 1'b1; end
      8'h3A: begin lower = "m"; letter = 1'b1; end
      8'h31: begin lower = "n"; letter = 1'b1; end
      8'h44: begin lower = "o"; letter = 1'b1; end
      8'h4D: begin lower = "p"; letter = 1'b1; end
      8'h15: begin lower = "q"; letter = 1'b1; end
      8'h2D: begin lower = "r"; letter = 1'b1; end
      8'h1B: begin lower = "s"; letter = 1'b1; end
      8'h2C: begin lower = "t"; letter = 1'b1; end
      8'h3C: begin lower = "u"; letter = 1'b1; end
      8'h2A: begin lower = "v"; letter = 1'b1; end
      8'h1D: begin lower = "w"; letter = 1'b1; end
      8'h22: begin lower = "x"; letter = 1'b1; end
      8'h35: begin lower = "y"; letter = 1'b1; end
      8'h1A: begin lower = "z"; letter = 1'b1; end
      8'h45: lower = "0";
      8'h16: lower = "1";
      8'h1E: lower = "2";
      8'h26: lower = "3";
      8'h25: lower = "4";
      8'h2E: lower = "5";
      8'h36: lower = "6";
      8'h3D: lower = "7";
      8'h3E: lower = "8";
      8'h46: lower = "9";
      8'h29: lower = 8'h20;
      8'h5A: lower = 8'h0D;
      8'h66: lower = 8'h08;
      default: lower = 8'h00;
    endcase
    // Lower to upper case is a single bit flip in ASCII.
    ascii = (letter && upper) ? (lower & 8'hDF) : lower;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - folds Set-2 prefixes into key events and buffers them in a FWFT FIFO
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_DONE,
  input  logic       iRD,
  output logic       oVALID,
  output logic [7:0] oKEY_CODE,
  output logic       oKEY_EXT,
  output logic       oKEY_BREAK,
  output logic [7:0] oKEY_ASCII,
  output logic       oCAPS,
  output logic       oOVF,
  output logic       oFIFO_FULL
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t        state, state_n;
  logic          shift_l, shift_r, caps;
  logic          ev, ev_ext, ev_brk;
  logic [7:0]    map_ascii;
  fifo_entry_t   entry, head_n;
  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0] count, count_n;
  logic          push, pop;

  ps2_scan2ascii u_map (
    .code  (iRX_DATA),
    .upper ((shift_l | shift_r) ^ caps),
    .ascii (map_ascii)
  );

  always_comb begin
    state_n = state;
    ev      = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (iRX_DONE && !is_dropped(iRX_DATA)) begin
      if (iRX_DATA == PFX_EXT && state != ST_E0) begin
        state_n = ST_E0;
      end else if (iRX_DATA == PFX_BRK && state == ST_IDLE) begin
        state_n = ST_F0;
      end else if (iRX_DATA == PFX_BRK && state == ST_E0) begin
        state_n = ST_E0F0;
      end else begin
        ev      = 1'b1;
        ev_ext  = (state == ST_E0) || (state == ST_E0F0);
        ev_brk  = (state == ST_F0) || (state == ST_E0F0);
        state_n = ST_IDLE;
      end
    end
  end

  always_comb begin
    entry.ext   = ev_ext;
    entry.brk   = ev_brk;
    entry.code  = iRX_DATA;
    entry.ascii = ev_ext ? 8'h00 : map_ascii;
  end

  assign pop  = iRD & oVALID;
  assign push = ev & (~oFIFO_FULL | pop);
  assign rd_n = rd_ptr + AW'(pop);

  // Head registers are loaded from the post-edge FIFO state so outputs stay registered.
  always_comb begin
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    if (count_n == '0) begin
      head_n = '0;
    end else if (push && wr_ptr == rd_n) begin
      head_n = entry;
    end else begin
      head_n = mem[rd_n];
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      state      <= ST_IDLE;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      caps       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      oVALID     <= 1'b0;
      oFIFO_FULL <= 1'b0;
      oOVF       <= 1'b0;
      oKEY_EXT   <= 1'b0;
      oKEY_BREAK <= 1'b0;
      oKEY_CODE  <= 8'h00;
      oKEY_ASCII <= 8'h00;
    end else begin
      state <= state_n;
      if (ev && !ev_ext) begin
        case (iRX_DATA)
          SC_LSHIFT: shift_l <= ~ev_brk;
          SC_RSHIFT: shift_r <= ~ev_brk;
          SC_CAPS:   if (!ev_brk) caps <= ~caps;
          default:   ;
        endcase
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr     <= rd_n;
      count      <= count_n;
      oVALID     <= (count_n != '0);
      oFIFO_FULL <= (count_n == FULL_CNT);
      if (ev && oFIFO_FULL && !pop) begin
        oOVF <= 1'b1;
      end
      oKEY_EXT   <= head_n.ext;
      oKEY_BREAK <= head_n.brk;
      oKEY_CODE  <= head_n.code;
      oKEY_ASCII <= head_n.ascii;
    end
  end

  assign oCAPS = caps;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - table-driven and scoreboard bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd;
  logic       valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic       caps;
  logic       ovf;
  logic       fifo_full;

  int total = 0;
  int bad   = 0;
  logic [17:0] sb[$];

  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [7:0] fill_code[9];
  logic [7:0] fill_asc[9];

  ps2_scancode_decoder #(.DEPTH(8)) dut (
    .iCLK_50    (clk),
    .iRST       (rst),
    .iRX_DATA   (rx_data),
    .iRX_DONE   (rx_done),
    .iRD        (rd),
    .oVALID     (valid),
    .oKEY_CODE  (key_code),
    .oKEY_EXT   (key_ext),
    .oKEY_BREAK (key_break),
    .oKEY_ASCII (key_ascii),
    .oCAPS      (caps),
    .oOVF       (ovf),
    .oFIFO_FULL (fifo_full)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    logic [17:0] exp;
    while (valid && guard < 40) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 18'h3FFFF;
      chk(name, {14'd0, key_ext, key_break, key_code, key_ascii}, {14'd0, exp});
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      guard++;
    end
    chk({name, "_left"}, sb.size(), 0);
    chk({name, "_idle_head"}, {14'd0, key_ext, key_break, key_code, key_ascii}, 0);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rd = 1'b0;

    vecs[0]  = '{48'h1C, 1, {2'b00, 8'h1C, 8'h61}};
    vecs[1]  = '{48'h1A, 1, {2'b00, 8'h1A, 8'h7A}};
    vecs[2]  = '{48'h45, 1, {2'b00, 8'h45, 8'h30}};
    vecs[3]  = '{48'h46, 1, {2'b00, 8'h46, 8'h39}};
    vecs[4]  = '{48'h29, 1, {2'b00, 8'h29, 8'h20}};
    vecs[5]  = '{48'h5A, 1, {2'b00, 8'h5A, 8'h0D}};
    vecs[6]  = '{48'h66, 1, {2'b00, 8'h66, 8'h08}};
    vecs[7]  = '{48'hF04D, 2, {2'b01, 8'h4D, 8'h70}};
    vecs[8]  = '{48'hE075, 2, {2'b10, 8'h75, 8'h00}};
    vecs[9]  = '{48'hE0F075, 3, {2'b11, 8'h75, 8'h00}};
    vecs[10] = '{48'hF0E06B, 3, {2'b10, 8'h6B, 8'h00}};
    vecs[11] = '{48'hF0AAFAE116, 5, {2'b01, 8'h16, 8'h31}};
    vecs[12] = '{48'h0D, 1, {2'b00, 8'h0D, 8'h00}};
    vecs[13] = '{48'hE05A, 2, {2'b10, 8'h5A, 8'h00}};
    vecs[14] = '{48'h00FFEEFE2D, 5, {2'b00, 8'h2D, 8'h72}};

    fill_code = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    fill_asc  = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_head", {14'd0, key_ext, key_break, key_code, key_ascii}, 0);
    chk("rst_caps", caps, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_full", fifo_full, 0);

    // make then break of 'a'; valid one cycle after the strobe
    send(8'h1C);
    sb.push_back({2'b00, 8'h1C, 8'h61});
    chk("first_latency", valid, 1);
    send(8'hF0);
    send(8'h1C);
    sb.push_back({2'b01, 8'h1C, 8'h61});
    drain("make_break");

    for (int i = 0; i < 15; i++) begin
      for (int k = vecs[i].n - 1; k >= 0; k--) begin
        logic [47:0] w;
        w = vecs[i].bytes >> (8 * k);
        send(w[7:0]);
      end
      sb.push_back(vecs[i].exp);
      drain($sformatf("vec%0d", i));
    end

    // shift and caps
    send(8'h12); sb.push_back({2'b00, 8'h12, 8'h00});
    send(8'h1C); sb.push_back({2'b00, 8'h1C, 8'h41});
    send(8'hF0); send(8'h12); sb.push_back({2'b01, 8'h12, 8'h00});
    send(8'h58); sb.push_back({2'b00, 8'h58, 8'h00});
    chk("caps_on", caps, 1);
    send(8'h1C); sb.push_back({2'b00, 8'h1C, 8'h41});
    send(8'hF0); send(8'h58); sb.push_back({2'b01, 8'h58, 8'h00});
    chk("caps_break_hold", caps, 1);
    send(8'h58); sb.push_back({2'b00, 8'h58, 8'h00});
    chk("caps_off", caps, 0);
    drain("modifiers");

    // overflow: ninth event dropped
    for (int i = 0; i < 9; i++) begin
      send(fill_code[i]);
      if (i < 8) sb.push_back({2'b00, fill_code[i], fill_asc[i]});
      if (i == 7) begin
        chk("full_at8", fifo_full, 1);
        chk("no_ovf_at8", ovf, 0);
      end
    end
    chk("full_after9", fifo_full, 1);
    chk("ovf_after9", ovf, 1);
    drain("overflow");
    chk("ovf_sticky", ovf, 1);

    // simultaneous push and pop while full
    pulse_reset();
    chk("ovf_cleared", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      send(fill_code[i]);
      sb.push_back({2'b00, fill_code[i], fill_asc[i]});
    end
    chk("full_again", fifo_full, 1);
    @(negedge clk);
    chk("pp_head", {14'd0, key_ext, key_break, key_code, key_ascii}, {14'd0, sb.pop_front()});
    rd = 1'b1;
    rx_data = 8'h43;
    rx_done = 1'b1;
    sb.push_back({2'b00, 8'h43, 8'h69});
    @(negedge clk);
    rd = 1'b0;
    rx_done = 1'b0;
    chk("pp_full", fifo_full, 1);
    chk("pp_no_ovf", ovf, 0);
    drain("push_pop_full");

    // reset in the middle of a prefixed sequence
    send(8'h58);
    send(8'hE0);
    send(8'hF0);
    pulse_reset();
    chk("midrst_caps", caps, 0);
    chk("midrst_valid", valid, 0);
    send(8'h1C);
    sb.push_back({2'b00, 8'h1C, 8'h61});
    chk("midrst_ovf", ovf, 0);
    drain("mid_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 receive stage: one 8-bit frame per `iRX_DONE` pulse. It folds the Set-2 prefixes 0xE0 (extended) and 0xF0 (break) into single key events and tracks Shift and Caps Lock state. Each event is translated to ASCII and buffered in a first-word-fall-through FIFO. The LCD text writer downstream reads the FIFO at its own pace.

## Interface
Parameters:
- `DEPTH`, default 8: event FIFO depth; power of two, at least 2.

Ports:
- `iCLK_50`  in  1  system clock, 50 MHz
- `iRST`  in  1  asynchronous reset, active-high
- `iRX_DATA`  in  8  received scan byte; valid only while `iRX_DONE` is high
- `iRX_DONE`  in  1  one-cycle strobe, one per received frame
- `iRD`  in  1  pop the head event; ignored while `oVALID` = 0
- `oVALID`  out  1  FIFO not empty
- `oKEY_CODE`  out  8  head event: scan code, prefixes stripped
- `oKEY_EXT`  out  1  head event: 0xE0 prefix was present
- `oKEY_BREAK`  out  1  head event: release (0xF0 prefix was present)
- `oKEY_ASCII`  out  8  head event: ASCII value, 0x00 if the key is unmapped
- `oCAPS`  out  1  Caps Lock state
- `oOVF`  out  1  sticky overflow flag; an event was dropped
- `oFIFO_FULL`  out  1  FIFO full

## Operation
- Prefix FSM states: IDLE, E0, F0, E0F0. The FSM advances only on `iRX_DONE`.
  - IDLE: byte 0xE0 goes to E0; byte 0xF0 goes to F0.
  - E0: byte 0xF0 goes to E0F0.
  - Any other byte in any state emits an event and returns to IDLE. `ext` = 1 if the state is E0 or E0F0. `brk` = 1 if the state is F0 or E0F0.
  - Byte 0xE0 while in F0 or E0F0 is a protocol error: go to E0, emit nothing.
- Dropped bytes: 0xE1, 0xAA, 0xFA, 0xFE, 0xEE, 0x00 and 0xFF are discarded in every state. They do not change the FSM state.
- Modifiers, non-extended only:
  - 0x12 sets or clears `shift_l`; 0x59 sets or clears `shift_r`. Make sets, break clears.
  - A 0x58 make toggles `caps`. A 0x58 break has no effect.
  - Modifier events are still pushed to the FIFO, with ASCII 0x00.
- ASCII mapping, non-extended only; extended keys give 0x00:
  - Letters map to a–z. They become A–Z when (`shift_l` | `shift_r`) XOR `caps`.
  - Digit row maps to 0–9, unaffected by Shift.
  - 0x29 maps to 0x20 (space), 0x5A to 0x0D (enter), 0x66 to 0x08 (backspace).
  - All other codes map to 0x00.
  - ASCII is computed for both make and break events. It uses the modifier state from before the current event.
- FIFO entry is {`ext`, `brk`, `code[7:0]`, `ascii[7:0]`}, 18 bits.
  - Push: an event is emitted and the FIFO is not full.
  - Push while full: drop the event and set `oOVF`. `oOVF` clears only on reset.
  - Push and pop in the same cycle while full: both happen; nothing is dropped.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally. A separate count of width `$clog2(DEPTH)+1` distinguishes full from empty.
- Reset values: FSM in IDLE, FIFO empty, `shift_l` = `shift_r` = `caps` = 0, `oOVF` = 0.
  - All head outputs (`oKEY_CODE`, `oKEY_EXT`, `oKEY_BREAK`, `oKEY_ASCII`) read 0 while `oVALID` = 0.
  - A reset between a prefix byte and its final byte discards the partial sequence.

## Timing
- An event is written on the clock edge that samples the final byte's `iRX_DONE`. `oVALID` and the head outputs update on that same edge, so there is 1 cycle of latency.
- Modifier and `oCAPS` updates land on that same edge.
- A pop takes effect on the clock edge where `iRD` and `oVALID` are both high; the next entry appears immediately after that edge.
- Back-to-back `iRX_DONE` pulses are accepted every cycle; the block never stalls its input.
- All outputs are registered.

## Structure
- Package `ps2_pkg` holds:
  - the byte constants PFX_EXT = 0xE0, PFX_BRK = 0xF0, SC_LSHIFT, SC_RSHIFT, SC_CAPS and the dropped-byte constants;
  - the FSM state enum;
  - the packed FIFO entry struct.
- Sub-module `ps2_scan2ascii` is a purely combinational lookup with inputs `code` and `upper` and output `ascii`.
- The FIFO is inline in this module.

## Test plan
- Bytes 0x1C, then 0xF0 0x1C → two events: {0,0,0x1C,0x61} then {0,1,0x1C,0x61}. `oVALID` rises 1 cycle after the first `iRX_DONE`.
- Sequence 0x12, 0x1C, 0xF0 0x12, then 0x58, 0x1C → ASCII values 0x00, 0x41, 0x00, 0x00, 0x41, in that order. `oCAPS` = 1 after the 0x58 byte.
- Sequence 0xE0 0x75, then 0xE0 0xF0 0x75 → {1,0,0x75,0x00} then {1,1,0x75,0x00}. Also 0xF0 0xE0 0x6B yields only {1,0,0x6B,0x00}.
- Push 9 events with `DEPTH` = 8 and `iRD` = 0 → `oFIFO_FULL` = 1, `oOVF` = 1, and the first 8 events pop back in order. Repeat with pop and push in the same cycle while full → no drop, `oOVF` stays 0.
- Bytes 0xAA, 0xFA, 0xE1 interleaved inside 0xF0 0x16 → single event {0,1,0x16,0x31}.
- Assert `iRST` after 0xE0 0xF0, then send 0x1C → event {0,0,0x1C,0x61}, with `caps` = 0 and `oOVF` = 0.
